// File: rtl/stopwatch_pkg.sv
// Shared types and default timing constants for the stopwatch front end.
// The downstream BCD counter stage also refers to TICK_CYCLES_DEFAULT.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    ARMED    = 2'd1,
    RUNNING  = 2'd2,
    WAIT_REL = 2'd3
  } state_e;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
  localparam int HOLD_CYCLES_DEFAULT     = 50_000_000;
  localparam int TICK_CYCLES_DEFAULT     = 500_000;

  // Counter width that stays legal for a terminal count of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus stable-level debounce for an active-low key.
// Reusable for any push-button, including the reset key.
module key_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_level
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          pressed_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  always_comb begin
    sync_d    = {sync_q[0], key_n};
    pressed_s = ~sync_q[1];
    cnt_d     = '0;
    level_d   = level_q;
    // Any cycle where the levels agree restarts the stability window.
    if (pressed_s != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = pressed_s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign key_level = level_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop/clear control for the 4-digit stopwatch: debounced key, FSM,
// hold-to-clear timer and the 100 Hz count-enable divider.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEFAULT,
  parameter int TICK_CYCLES     = TICK_CYCLES_DEFAULT
) (
  input  logic CLOCK_50,
  input  logic rst,
  input  logic key_n,
  output logic key_level,
  output logic running,
  output logic tick,
  output logic clear
);

  localparam int            HW        = cnt_width(HOLD_CYCLES);
  localparam int            TW        = cnt_width(TICK_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] div_q, div_d;
  logic          wrap_q, wrap_d;
  logic          key_prev_q, key_prev_d;
  logic          running_q, running_d;
  logic          tick_q, tick_d;
  logic          clear_q, clear_d;
  logic          key_level_s, press_s, release_s;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk      (CLOCK_50),
    .rst      (rst),
    .key_n    (key_n),
    .key_level(key_level_s)
  );

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state_q    <= STOPPED;
      hold_q     <= '0;
      div_q      <= '0;
      wrap_q     <= 1'b0;
      key_prev_q <= 1'b0;
      running_q  <= 1'b0;
      tick_q     <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      div_q      <= div_d;
      wrap_q     <= wrap_d;
      key_prev_q <= key_prev_d;
      running_q  <= running_d;
      tick_q     <= tick_d;
      clear_q    <= clear_d;
    end
  end

  always_comb begin
    key_prev_d = key_level_s;
    press_s    = key_level_s & ~key_prev_q;
    release_s  = ~key_level_s & key_prev_q;
    state_d    = state_q;
    hold_d     = hold_q;
    clear_d    = 1'b0;
    div_d      = div_q;
    wrap_d     = 1'b0;

    case (state_q)
      STOPPED: begin
        if (press_s) begin
          state_d = ARMED;
          hold_d  = '0;
        end
      end
      ARMED: begin
        if (hold_q == HOLD_LAST) begin
          clear_d = 1'b1;
          state_d = WAIT_REL;
        end else if (release_s) begin
          state_d = RUNNING;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      // Stopping on the press edge, not the release, keeps the time accurate.
      RUNNING: begin
        if (press_s) begin
          state_d = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!key_level_s) begin
          state_d = STOPPED;
        end
      end
      default: state_d = STOPPED;
    endcase

    // Divider freezes outside RUNNING so the fractional phase survives a stop.
    if (state_q == RUNNING) begin
      if (div_q == TICK_LAST) begin
        div_d  = '0;
        wrap_d = 1'b1;
      end else begin
        div_d = div_q + TW'(1);
      end
    end
    if (clear_d) begin
      div_d = '0;
    end

    running_d = (state_d == RUNNING);
    tick_d    = wrap_q;
  end

  assign key_level = key_level_s;
  assign running   = running_q;
  assign tick      = tick_q;
  assign clear     = clear_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with DEBOUNCE=4, HOLD=20, TICK=5.
// Stimulus pushes expected output events (value, cycle); a monitor pops them.
module tb_stopwatch_ctrl;

  logic CLOCK_50 = 1'b0;
  logic rst;
  logic key_n;
  logic key_level, running, tick, clear;

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (20),
    .TICK_CYCLES    (5)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .key_n    (key_n),
    .key_level(key_level),
    .running  (running),
    .tick     (tick),
    .clear    (clear)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {
    logic v;
    int   c;
  } ev_t;

  ev_t q_kl[$];
  ev_t q_run[$];
  int  q_tick[$];
  int  q_clr[$];

  int   n_total = 0;
  int   n_pass  = 0;
  bit   mon_en  = 1'b0;
  logic kl_prev = 1'b0;
  logic run_prev = 1'b0;
  ev_t  mon_e;
  int   mon_c;

  task automatic check(input bit ok, input string name, input int act_v, input int act_c,
                       input int exp_v, input int exp_c);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got value %0d at cycle %0d, expected value %0d at cycle %0d",
                  name, act_v, act_c, exp_v, exp_c);
  endtask

  // Monitor: every output change (or tick/clear high cycle) consumes one expectation.
  always @(negedge CLOCK_50) begin
    if (mon_en) begin
      if (key_level !== kl_prev) begin
        mon_e = '{1'b0, -1};
        if (q_kl.size() > 0) mon_e = q_kl.pop_front();
        check(key_level === mon_e.v && cyc == mon_e.c, "key_level",
              int'(key_level), cyc, int'(mon_e.v), mon_e.c);
      end
      if (running !== run_prev) begin
        mon_e = '{1'b0, -1};
        if (q_run.size() > 0) mon_e = q_run.pop_front();
        check(running === mon_e.v && cyc == mon_e.c, "running",
              int'(running), cyc, int'(mon_e.v), mon_e.c);
      end
      if (tick !== 1'b0) begin
        mon_c = -1;
        if (q_tick.size() > 0) mon_c = q_tick.pop_front();
        check(tick === 1'b1 && cyc == mon_c, "tick", int'(tick), cyc, 1, mon_c);
      end
      if (clear !== 1'b0) begin
        mon_c = -1;
        if (q_clr.size() > 0) mon_c = q_clr.pop_front();
        check(clear === 1'b1 && cyc == mon_c, "clear", int'(clear), cyc, 1, mon_c);
      end
    end
    kl_prev  = key_level;
    run_prev = running;
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge CLOCK_50);
  endtask

  // Hold the key for len cycles from the current negedge; key_level follows 6 edges later.
  task automatic tap(input int len, output int c0);
    c0    = cyc;
    key_n = 1'b0;
    q_kl.push_back('{1'b1, c0 + 6});
    repeat (len) @(negedge CLOCK_50);
    key_n = 1'b1;
    q_kl.push_back('{1'b0, c0 + len + 6});
  endtask

  task automatic check_outputs_low(input string tag);
    check(key_level === 1'b0, {tag, "_key_level"}, int'(key_level), cyc, 0, cyc);
    check(running === 1'b0, {tag, "_running"}, int'(running), cyc, 0, cyc);
    check(tick === 1'b0, {tag, "_tick"}, int'(tick), cyc, 0, cyc);
    check(clear === 1'b0, {tag, "_clear"}, int'(clear), cyc, 0, cyc);
  endtask

  int c, r, p, q, r2, p2, m, m2, r3, x, z, r4;

  initial begin
    rst   = 1'b1;
    key_n = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    check_outputs_low("reset");
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(negedge CLOCK_50);

    // Bounce: 3-low/2-high bursts never reach the debounce threshold.
    for (int i = 0; i < 10; i++) begin
      key_n = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      key_n = 1'b1;
      repeat (2) @(negedge CLOCK_50);
    end
    repeat (10) @(negedge CLOCK_50);

    // Clean short press starts the watch on release; ticks from a cleared divider.
    tap(10, c);
    r = c + 17;
    q_run.push_back('{1'b1, r});
    for (int k = 0; k < 10; k++) q_tick.push_back(r + 6 + 5 * k);

    // Stop after 52 counted cycles: divider left at phase 2.
    wait_until(r + 45);
    p = cyc;
    q_run.push_back('{1'b0, p + 7});
    tap(10, p);

    // Restart: next tick after the remaining 3 counts.
    wait_until(p + 25);
    q = cyc;
    q_run.push_back('{1'b1, q + 17});
    tap(10, q);
    r2 = q + 17;
    for (int k = 0; k < 4; k++) q_tick.push_back(r2 + 4 + 5 * k);

    // Long press while running: stop only, never a clear.
    wait_until(r2 + 13);
    p2 = cyc;
    q_run.push_back('{1'b0, p2 + 7});
    tap(25, p2);

    // Long press while stopped: one clear 20 cycles after ARMED entry.
    wait_until(p2 + 45);
    m = cyc;
    q_clr.push_back(m + 27);
    tap(25, m);

    // Start again: divider was zeroed by the clear.
    wait_until(m + 45);
    m2 = cyc;
    q_run.push_back('{1'b1, m2 + 17});
    tap(10, m2);
    r3 = m2 + 17;
    q_tick.push_back(r3 + 6);
    q_tick.push_back(r3 + 11);

    // Reset mid-count with the key held through deassertion.
    wait_until(r3 + 13);
    x = cyc;
    q_run.push_back('{1'b0, x + 1});
    #2;
    rst   = 1'b1;
    key_n = 1'b0;
    #1;
    check_outputs_low("midreset");
    repeat (3) @(negedge CLOCK_50);
    z   = cyc;
    rst = 1'b0;
    q_kl.push_back('{1'b1, z + 6});
    repeat (10) @(negedge CLOCK_50);
    key_n = 1'b1;
    q_kl.push_back('{1'b0, z + 16});
    r4 = z + 17;
    q_run.push_back('{1'b1, r4});
    q_tick.push_back(r4 + 6);
    wait_until(r4 + 9);
    @(negedge CLOCK_50);

    check(q_kl.size() == 0, "key_level_pending", q_kl.size(), cyc, 0, cyc);
    check(q_run.size() == 0, "running_pending", q_run.size(), cyc, 0, cyc);
    check(q_tick.size() == 0, "tick_pending", q_tick.size(), cyc, 0, cyc);
    check(q_clr.size() == 0, "clear_pending", q_clr.size(), cyc, 0, cyc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
